lw_mailbox_slave: RTL and testbench

Avalon-MM slave that terminates the HPS lightweight bridge master (`lw_bridge_m0_*`) in the FPGA fabric and gives the host a register-mapped mailbox. Host writes go into a TX FIFO that drains onto a valid/ready stream toward openPOWERLINK fabric logic. Fabric words arrive on a second stream into an RX FIFO that the host reads. The `irq` output drives the `hostif_irq_i_irq` input of the SoC system.

---
 rtl/lw_mailbox_slave.sv | 187 ++++++++++++++++++
 tb/tb_lw_mailbox_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_mailbox_slave.sv
// Avalon-MM mailbox slave for the HPS lightweight bridge: host-written TX FIFO
// drained onto a valid/ready stream, and a fabric-fed RX FIFO read back by the host.

module lw_mailbox_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr];
    // A flushing FIFO ignores both sides for that cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module lw_mailbox_slave #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ID_VALUE   = 32'h504C_4B31
) (
    input  logic        clk100_clk,
    input  logic        reset_clk100_reset,
    input  logic [17:0] s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_writedata,
    input  logic [3:0]  s0_byteenable,
    input  logic        s0_burstcount,
    input  logic        s0_debugaccess,
    output logic        s0_waitrequest,
    output logic [31:0] s0_readdata,
    output logic        s0_readdatavalid,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam int DATA_W = 32;
    localparam int LW     = $clog2(FIFO_DEPTH) + 1;

    logic              rst;
    logic              rst_done;
    logic              tx_flush_p0;
    logic              rx_flush_p0;
    logic              irq_en;
    logic              tx_overflow;
    logic              addr_ok;
    logic [2:0]        reg_idx;
    logic              wr_acc;
    logic              rd_acc;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [LW-1:0]     tx_level, rx_level;
    logic [31:0]       status_word;
    logic [31:0]       rd_mux;
    logic [31:0]       rd_data_p0;
    logic              rd_vld_p0;
    logic              unused_ok;

    assign rst       = reset_clk100_reset;
    assign unused_ok = ^{s0_address[1:0], s0_byteenable[3:1], s0_burstcount, s0_debugaccess};

    assign s0_waitrequest = rst | ~rst_done | tx_flush_p0 | rx_flush_p0;
    assign addr_ok = (s0_address[17:5] == '0);
    assign reg_idx = s0_address[4:2];
    assign wr_acc  = s0_write & ~s0_waitrequest & addr_ok;
    assign rd_acc  = s0_read & ~s0_write & ~s0_waitrequest;

    assign tx_push  = wr_acc & (reg_idx == 3'd4);
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_valid ? tx_head : '0;

    assign rx_ready = rst_done & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rd_acc & addr_ok & (reg_idx == 3'd5) & ~rx_empty;

    assign status_word = {8'(rx_level), 8'(tx_level), 13'b0, tx_overflow, tx_full, ~rx_empty};

    lw_mailbox_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk(clk100_clk), .rst(rst), .flush(tx_flush_p0), .push(tx_push), .pop(tx_pop),
        .wdata(s0_writedata), .rdata(tx_head), .level(tx_level), .full(tx_full), .empty(tx_empty)
    );

    lw_mailbox_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk(clk100_clk), .rst(rst), .flush(rx_flush_p0), .push(rx_push), .pop(rx_pop),
        .wdata(rx_data), .rdata(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk100_clk) begin
        if (rst) begin
            rst_done    <= 1'b0;
            tx_flush_p0 <= 1'b0;
            rx_flush_p0 <= 1'b0;
            irq_en      <= 1'b0;
            tx_overflow <= 1'b0;
            irq         <= 1'b0;
        end else begin
            rst_done    <= 1'b1;
            tx_flush_p0 <= 1'b0;
            rx_flush_p0 <= 1'b0;
            if (wr_acc && reg_idx == 3'd1 && s0_byteenable[0]) begin
                irq_en      <= s0_writedata[0];
                tx_flush_p0 <= s0_writedata[1];
                rx_flush_p0 <= s0_writedata[2];
            end
            // Fullness is judged before any same-cycle pop, so a drain cannot rescue the push.
            if (tx_push && tx_full)
                tx_overflow <= 1'b1;
            else if (wr_acc && reg_idx == 3'd2 && s0_writedata[2])
                tx_overflow <= 1'b0;
            irq <= irq_en & (~rx_empty | tx_overflow);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr_ok) begin
            case (reg_idx)
                3'd0:    rd_mux = ID_VALUE;
                3'd1:    rd_mux = {31'b0, irq_en};
                3'd2:    rd_mux = status_word;
                3'd5:    rd_mux = rx_empty ? '0 : rx_head;
                default: rd_mux = '0;
            endcase
        end
    end

    // Stage p0: capture read response in the accept cycle
    always_ff @(posedge clk100_clk) begin
        rd_data_p0 <= rd_mux;
    end

    // Stage p1: present response on the bus two cycles after accept
    always_ff @(posedge clk100_clk) begin
        if (rst) begin
            rd_vld_p0        <= 1'b0;
            s0_readdatavalid <= 1'b0;
            s0_readdata      <= '0;
        end else begin
            rd_vld_p0        <= rd_acc;
            s0_readdatavalid <= rd_vld_p0;
            if (rd_vld_p0) s0_readdata <= rd_data_p0;
        end
    end
endmodule

// File: tb/tb_lw_mailbox_slave.sv
// Directed bench for lw_mailbox_slave: register map, FIFO streams, flush, irq and reset.

module tb_lw_mailbox_slave;
    localparam logic [31:0] ID = 32'h504C_4B31;

    logic        clk;
    logic        rst;
    logic [17:0] s0_address;
    logic        s0_read;
    logic        s0_write;
    logic [31:0] s0_writedata;
    logic [3:0]  s0_byteenable;
    logic        s0_burstcount;
    logic        s0_debugaccess;
    logic        s0_waitrequest;
    logic [31:0] s0_readdata;
    logic        s0_readdatavalid;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int checks;
    int errors;

    lw_mailbox_slave dut (
        .clk100_clk(clk), .reset_clk100_reset(rst),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_burstcount(s0_burstcount), .s0_debugaccess(s0_debugaccess),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
        s0_address = a; s0_writedata = d; s0_byteenable = be; s0_write = 1'b1;
        step();
        s0_write = 1'b0; s0_byteenable = 4'hF;
    endtask

    task automatic do_read(input logic [17:0] a, output logic [31:0] d, output int lat);
        s0_address = a; s0_read = 1'b1;
        step();
        s0_read = 1'b0; lat = -1; d = '0;
        for (int i = 1; i <= 4; i++) begin
            if (s0_readdatavalid && lat < 0) begin lat = i; d = s0_readdata; end
            step();
        end
    endtask

    task automatic push_rx(input logic [31:0] d);
        rx_data = d; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (s0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq got %b exp 1", s0_waitrequest); end
        checks++; if ({s0_readdatavalid, s0_readdata} !== 33'b0) begin errors++; $display("FAIL rst_readdata got %b/%h exp 0/0", s0_readdatavalid, s0_readdata); end
        checks++; if ({tx_valid, tx_data} !== 33'b0) begin errors++; $display("FAIL rst_tx got %b/%h exp 0/0", tx_valid, tx_data); end
        checks++; if ({rx_ready, irq} !== 2'b00) begin errors++; $display("FAIL rst_rxready_irq got %b%b exp 00", rx_ready, irq); end
        rst = 1'b0;
        #1;
        checks++; if ({s0_waitrequest, rx_ready} !== 2'b10) begin errors++; $display("FAIL release1 waitreq/rx_ready got %b%b exp 10", s0_waitrequest, rx_ready); end
        step();
        checks++; if ({s0_waitrequest, rx_ready} !== 2'b01) begin errors++; $display("FAIL release2 waitreq/rx_ready got %b%b exp 01", s0_waitrequest, rx_ready); end
    endtask

    task automatic test_id_status();
        logic [31:0] d; int lat;
        do_read(18'h00, d, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL id_latency got %0d exp 2", lat); end
        checks++; if (d !== ID) begin errors++; $display("FAIL id_data got %h exp %h", d, ID); end
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_reset got %h exp 0", d); end
        do_read(18'h0C, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_0c got %h exp 0", d); end
        do_read(18'h20, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL high_addr_read got %h exp 0", d); end
        do_write(18'h24, 32'h1, 4'h1);
        do_read(18'h04, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL high_addr_write ctrl got %h exp 0", d); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d; int lat;
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_idle got %b exp 0", tx_valid); end
        for (int i = 1; i <= 16; i++) begin
            do_write(18'h10, 32'(i), 4'hF);
            if (i == 1) begin
                checks++; if ({tx_valid, tx_data} !== {1'b1, 32'd1}) begin errors++; $display("FAIL tx_first got %b/%h exp 1/1", tx_valid, tx_data); end
            end
        end
        do_write(18'h10, 32'd99, 4'hF);
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0010_0006) begin errors++; $display("FAIL tx_full_status got %h exp 00100006", d); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++; if ({tx_valid, tx_data} !== {1'b1, 32'(i)}) begin errors++; $display("FAIL tx_drain[%0d] got %b/%h exp 1/%h", i, tx_valid, tx_data, i); end
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
        do_write(18'h08, 32'h4, 4'hF);
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL overflow_w1c got %h exp 0", d); end
    endtask

    task automatic test_rx_irq();
        logic [31:0] d; int lat;
        do_write(18'h04, 32'h1, 4'h1);
        rx_data = 32'hA5A5_0001; rx_valid = 1'b1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_idle got %b exp 1", rx_ready); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
        rx_data = 32'h5A5A_0002;
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
        rx_data = 32'hDEAD_BEEF;
        step();
        rx_valid = 1'b0;
        do_read(18'h14, d, lat);
        checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL rx_pop_a got %h exp a5a50001", d); end
        do_read(18'h14, d, lat);
        checks++; if (d !== 32'h5A5A_0002) begin errors++; $display("FAIL rx_pop_b got %h exp 5a5a0002", d); end
        do_read(18'h14, d, lat);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rx_pop_c got %h exp deadbeef", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
        do_read(18'h14, d, lat);
        checks++; if (lat !== 2 || d !== 32'h0) begin errors++; $display("FAIL rx_empty_read got %h lat %0d exp 0 lat 2", d, lat); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; int lat;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin rx_data = 32'(100 + i); step(); end
        rx_valid = 1'b0;
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0500_0001) begin errors++; $display("FAIL level5_status got %h exp 05000001", d); end
        rx_data = 32'd105; rx_valid = 1'b1; s0_address = 18'h14; s0_read = 1'b1;
        step();
        rx_valid = 1'b0; s0_read = 1'b0;
        step();
        checks++; if ({s0_readdatavalid, s0_readdata} !== {1'b1, 32'd100}) begin errors++; $display("FAIL same_cycle_pop got %b/%h exp 1/64", s0_readdatavalid, s0_readdata); end
        step();
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0500_0001) begin errors++; $display("FAIL same_cycle_level got %h exp 05000001", d); end
        for (int i = 1; i <= 5; i++) begin
            do_read(18'h14, d, lat);
            checks++; if (d !== 32'(100 + i)) begin errors++; $display("FAIL same_cycle_order[%0d] got %0d exp %0d", i, d, 100 + i); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] d; int lat;
        tx_ready = 1'b0;
        for (int i = 7; i <= 10; i++) do_write(18'h10, 32'(i), 4'hF);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_flush_tx got %b exp 1", tx_valid); end
        do_write(18'h04, 32'h2, 4'h1);
        checks++; if (s0_waitrequest !== 1'b1) begin errors++; $display("FAIL flush_waitreq got %b exp 1", s0_waitrequest); end
        step();
        checks++; if ({s0_waitrequest, tx_valid} !== 2'b00) begin errors++; $display("FAIL flush_done waitreq/tx_valid got %b%b exp 00", s0_waitrequest, tx_valid); end
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_flush_status got %h exp 0", d); end
        push_rx(32'd1); push_rx(32'd2);
        do_write(18'h04, 32'h4, 4'h1);
        rx_data = 32'd77; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_flush_status got %h exp 0", d); end
        do_write(18'h04, 32'h1, 4'b1110);
        do_read(18'h04, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_be_masked got %h exp 0", d); end
        do_write(18'h04, 32'h1, 4'b0001);
        do_read(18'h04, d, lat);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_be_lane0 got %h exp 1", d); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] addrs [4];
        logic [31:0] exps  [4];
        logic        vexp;
        addrs = '{18'h00, 18'h04, 18'h08, 18'h00};
        exps  = '{ID, 32'h1, 32'h0, ID};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin s0_address = addrs[i]; s0_read = 1'b1; end
            else s0_read = 1'b0;
            vexp = (i >= 2 && i < 6);
            checks++; if (s0_readdatavalid !== vexp) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, s0_readdatavalid, vexp); end
            if (i >= 2 && i < 6) begin
                checks++; if (s0_readdata !== exps[i-2]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, s0_readdata, exps[i-2]); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d; int lat;
        push_rx(32'h1234);
        do_write(18'h10, 32'h55, 4'hF);
        step();
        checks++; if ({irq, tx_valid} !== 2'b11) begin errors++; $display("FAIL pre_reset irq/tx_valid got %b%b exp 11", irq, tx_valid); end
        s0_address = 18'h00; s0_read = 1'b1;
        step(); step();
        checks++; if (s0_readdatavalid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", s0_readdatavalid); end
        rst = 1'b1; s0_read = 1'b0;
        step();
        checks++; if ({s0_readdatavalid, s0_readdata} !== 33'b0) begin errors++; $display("FAIL mid_reset_read got %b/%h exp 0/0", s0_readdatavalid, s0_readdata); end
        checks++; if ({s0_waitrequest, tx_valid, rx_ready, irq} !== 4'b1000) begin errors++; $display("FAIL mid_reset_ctrl got %b exp 1000", {s0_waitrequest, tx_valid, rx_ready, irq}); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL mid_reset_txdata got %h exp 0", tx_data); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (s0_readdatavalid !== 1'b0) begin errors++; $display("FAIL post_reset_valid[%0d] got %b exp 0", i, s0_readdatavalid); end
            step();
        end
        do_read(18'h08, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_status got %h exp 0", d); end
        do_read(18'h04, d, lat);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_ctrl got %h exp 0", d); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; s0_address = '0; s0_read = 1'b0; s0_write = 1'b0;
        s0_writedata = '0; s0_byteenable = 4'hF; s0_burstcount = 1'b1; s0_debugaccess = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        test_reset();
        test_id_status();
        test_tx_overflow();
        test_rx_irq();
        test_same_cycle();
        test_flush();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
